alu_mul_sequencer: RTL
======================

Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes an unsigned 32x32 -> 64-bit product by sequencing the shared 32-bit ALU in ADD mode (shift-and-add, one ALU add per cycle).
- Sits beside the execute stage.
- While busy it owns the ALU operand/control mux via alu_own.
- The core stalls on busy and captures the product on done.

Parameters:
- WIDTH, 32, operand width; only 32 is supported. Product is 2*WIDTH.
- ZERO_SKIP, 1, when 1 a zero operand finishes without iterating.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op_a  input  32  multiplicand; captured on accepted start
- op_b  input  32  multiplier; captured on accepted start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when the product is valid
- prod_hi  output  32  product bits [63:32]; held until next accepted start
- prod_lo  output  32  product bits [31:0]; held until next accepted start
- hi_nonzero  output  1  prod_hi != 0; valid with done, held with product
- alu_own  output  1  high in RUN; selects sequencer drives into the ALU
- alu_src_a  output  32  ALU SrcA
- alu_src_b  output  32  ALU SrcB
- alu_control  output  2  ALU op select; 2'b10 = ADD
- alu_result  input  32  ALU 32-bit result
- alu_carry  input  1  ALU carry out of the ADD

Behaviour:
- Reset (synchronous, active-high; dominates start):
  - State goes to IDLE.
  - busy, done, alu_own and hi_nonzero are 0.
  - prod_hi, prod_lo, alu_src_a and alu_src_b are 0. alu_control is 2'b00.
  - Internal registers (mcand, acc_hi, acc_lo, count) are cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - mcand<=op_a, acc_hi<=0, acc_lo<=op_b, count<=0.
  - If ZERO_SKIP=1 and (op_a==0 or op_b==0): next state DONE, and prod_hi/prod_lo<=0 (1 cycle start->done).
  - Otherwise: next state RUN.
- IDLE, start=0: remain in IDLE.
- RUN, combinational drives each cycle:
  - alu_own=1, busy=1, alu_control=2'b10.
  - alu_src_a=acc_hi.
  - alu_src_b = acc_lo[0] ? mcand : 0.
- RUN, at each edge:
  - acc_hi<={alu_carry, alu_result[31:1]}.
  - acc_lo<={alu_result[0], acc_lo[31:1]}.
  - count<=count+1.
  - When count==31: next state DONE, and prod_hi/prod_lo<=the updated acc_hi/acc_lo values.
- ALU timing: the ALU is combinational with no pipelining; the result is consumed in the same cycle.
- Latency:
  - start accepted at edge E: RUN for 32 cycles, first edge E+1, last edge E+32.
  - done is high during the cycle following edge E+32, i.e. 33 cycles after acceptance.
- DONE:
  - done=1 for exactly one cycle. busy=0, alu_own=0.
  - hi_nonzero=(prod_hi!=0).
  - Next state is always IDLE. start in DONE is ignored.
  - Back-to-back: a new start is accepted in the following IDLE cycle.
- start while in RUN or DONE: ignored; no effect on operands or count.
- alu_own=0 (IDLE, DONE): alu_src_a=0, alu_src_b=0, alu_control=2'b00.
- Product outputs: updated only on DONE entry; stable in IDLE and RUN (they show the previous result).
- Reset mid-RUN: abort immediately.
  - Cleanup takes effect at that edge: alu_own falls, no done pulse, prod_* cleared.
- Arithmetic:
  - All unsigned, modulo 2^64 product. Cannot overflow 64 bits.
  - acc_hi plus carry never exceeds 33 bits.
  - The ALU Overflow/Zero/Negative flags are unused.

Test Plan:
- Basic multiply: op_a=3, op_b=5, start 1 cycle -> busy high 32 cycles, done pulse on cycle 33; prod_hi=0, prod_lo=15, hi_nonzero=0. Every RUN cycle: alu_control=2'b10, alu_own=1.
- Carry path: op_a=op_b=32'hFFFFFFFF -> prod_hi=32'hFFFFFFFE, prod_lo=32'h00000001, hi_nonzero=1. Confirms alu_carry is shifted into acc_hi[31].
- Zero skip: op_a=0, op_b=32'h1234 (ZERO_SKIP=1) -> done the cycle after start, busy never high, product 0. With ZERO_SKIP=0 -> 33-cycle latency, product 0.
- Start ignored: start held high throughout a 7x9 run, with op_a/op_b changing mid-run -> result 63. done pulses once; second operation accepted only in IDLE after DONE.
- Reset mid-operation: reset at RUN cycle 10 -> next cycle IDLE, busy=0, alu_own=0, prod_*=0, no done. A subsequent 2x2 gives 4.
- Back-to-back: 32'h10000 x 32'h10000 then 6x7 -> first prod_hi=1, prod_lo=0; second prod_lo=42. Products stay stable between done pulses.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier controller that borrows the shared 32-bit ALU
// in ADD mode, one partial-product add per cycle, for a 64-bit product.
module alu_mul_sequencer #(
   parameter int WIDTH     = 32,
   parameter bit ZERO_SKIP = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo,
   output logic             hi_nonzero,
   output logic             alu_own,
   output logic [WIDTH-1:0] alu_src_a,
   output logic [WIDTH-1:0] alu_src_b,
   output logic [1:0]       alu_control,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [4:0]       count_q, count_d;
   logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
   logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
   logic             hi_nz_q, hi_nz_d;
   logic             zero_op_s;

   assign zero_op_s = (ZERO_SKIP != 1'b0) &&
                      ((op_a == {WIDTH{1'b0}}) || (op_b == {WIDTH{1'b0}}));

   // ALU drive and status decode; kept apart from next-state so the ALU path stays acyclic
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      alu_own     = 1'b0;
      alu_src_a   = {WIDTH{1'b0}};
      alu_src_b   = {WIDTH{1'b0}};
      alu_control = 2'b00;
      case (state_q)
         ST_RUN: begin
            busy        = 1'b1;
            alu_own     = 1'b1;
            alu_control = 2'b10;
            alu_src_a   = acc_hi_q;
            if (acc_lo_q[0]) begin
               alu_src_b = mcand_q;
            end else begin
               alu_src_b = {WIDTH{1'b0}};
            end
         end
         ST_DONE: done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Next-state, accumulator shift and product capture
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      count_d   = count_q;
      prod_hi_d = prod_hi_q;
      prod_lo_d = prod_lo_q;
      hi_nz_d   = hi_nz_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mcand_d  = op_a;
               acc_hi_d = {WIDTH{1'b0}};
               acc_lo_d = op_b;
               count_d  = 5'd0;
               if (zero_op_s) begin
                  state_d   = ST_DONE;
                  prod_hi_d = {WIDTH{1'b0}};
                  prod_lo_d = {WIDTH{1'b0}};
                  hi_nz_d   = 1'b0;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // carry lands in acc_hi[31]; the ALU's lsb shifts down into acc_lo
            acc_hi_d = {alu_carry, alu_result[WIDTH-1:1]};
            acc_lo_d = {alu_result[0], acc_lo_q[WIDTH-1:1]};
            count_d  = count_q + 5'd1;
            if (count_q == 5'd31) begin
               state_d   = ST_DONE;
               prod_hi_d = acc_hi_d;
               prod_lo_d = acc_lo_d;
               hi_nz_d   = (acc_hi_d != {WIDTH{1'b0}});
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         mcand_q   <= {WIDTH{1'b0}};
         acc_hi_q  <= {WIDTH{1'b0}};
         acc_lo_q  <= {WIDTH{1'b0}};
         count_q   <= 5'd0;
         prod_hi_q <= {WIDTH{1'b0}};
         prod_lo_q <= {WIDTH{1'b0}};
         hi_nz_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         count_q   <= count_d;
         prod_hi_q <= prod_hi_d;
         prod_lo_q <= prod_lo_d;
         hi_nz_q   <= hi_nz_d;
      end
   end

   assign prod_hi    = prod_hi_q;
   assign prod_lo    = prod_lo_q;
   assign hi_nonzero = hi_nz_q;

endmodule
